// File: rtl/instr_decode_stage.sv
// MIPS instruction-decode stage with a registered one-hot code and a
// two-entry skid buffer (output register plus skid register) on the
// valid/ready handshake between fetch and control/datapath.
module instr_decode_stage #(
    parameter int EXT_EN = 1,
    parameter int CODE_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code,
    output logic              illegal,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [15:0]       imm16,
    output logic [25:0]       target26
);

    // Returns the code bit index for a word, or -1 when nothing matches.
    function automatic int decode_index(input logic [31:0] w);
        int idx;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] f_rs;
        logic [4:0] f_rt;
        op   = w[31:26];
        fn   = w[5:0];
        f_rs = w[25:21];
        f_rt = w[20:16];
        idx  = -1;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100000: idx = 0;
                    6'b100001: idx = 1;
                    6'b100010: idx = 2;
                    6'b100011: idx = 3;
                    6'b100100: idx = 4;
                    6'b100101: idx = 5;
                    6'b100110: idx = 6;
                    6'b100111: idx = 7;
                    6'b101010: idx = 8;
                    6'b101011: idx = 9;
                    6'b000000: idx = 10;
                    6'b000010: idx = 11;
                    6'b000011: idx = 12;
                    6'b000100: idx = 13;
                    6'b000110: idx = 14;
                    6'b000111: idx = 15;
                    6'b001000: idx = 16;
                    6'b011000: idx = 31;
                    6'b011001: idx = 32;
                    6'b011010: idx = 33;
                    6'b011011: idx = 34;
                    6'b010000: idx = 35;
                    6'b010001: idx = 36;
                    6'b010010: idx = 37;
                    6'b010011: idx = 38;
                    6'b001001: idx = 39;
                    6'b001100: idx = 40;
                    6'b001101: idx = 41;
                    6'b110100: idx = 42;
                    default:   idx = -1;
                endcase
            end
            6'b001000: idx = 17;
            6'b001001: idx = 18;
            6'b001100: idx = 19;
            6'b001101: idx = 20;
            6'b001110: idx = 21;
            6'b100011: idx = 22;
            6'b101011: idx = 23;
            6'b000100: idx = 24;
            6'b000101: idx = 25;
            6'b001010: idx = 26;
            6'b001011: idx = 27;
            6'b001111: idx = 28;
            6'b000010: idx = 29;
            6'b000011: idx = 30;
            6'b000001: idx = (f_rt == 5'b00001) ? 43 : -1;
            6'b011100: idx = (fn == 6'b100000) ? 44 : -1;
            6'b100000: idx = 45;
            6'b100001: idx = 46;
            6'b100100: idx = 47;
            6'b100101: idx = 48;
            6'b101000: idx = 49;
            6'b101001: idx = 50;
            6'b010000: begin
                if (f_rs == 5'b00000)
                    idx = 51;
                else if (f_rs == 5'b00100)
                    idx = 52;
                else if (f_rs == 5'b10000 && fn == 6'b011000)
                    idx = 53;
                else
                    idx = -1;
            end
            default: idx = -1;
        endcase
        // Extended encodings are treated as unknown when the set is disabled.
        if (EXT_EN == 0 && idx >= 31)
            idx = -1;
        return idx;
    endfunction

    logic              skid_vld_p0;
    logic [31:0]       skid_word_p0;
    logic [25:0]       out_word_p1;
    logic              load_out;
    logic              in_fire;
    logic              take_skid;
    logic              take_in;
    logic              skid_next;
    logic [31:0]       load_word;
    logic [CODE_W-1:0] dec_code;
    logic              dec_illegal;
    int                dec_idx;

    // Handshake steering and decode of whichever word loads the output register.
    always_comb begin
        load_out    = !out_valid || out_ready;
        in_fire     = in_valid && in_ready;
        take_skid   = load_out && skid_vld_p0;
        take_in     = load_out && !skid_vld_p0 && in_fire;
        skid_next   = take_skid ? 1'b0 : ((!load_out && in_fire) ? 1'b1 : skid_vld_p0);
        load_word   = skid_vld_p0 ? skid_word_p0 : instr_in;
        dec_idx     = decode_index(load_word);
        dec_illegal = (dec_idx < 0);
        dec_code    = '0;
        for (int i = 0; i < CODE_W; i++) begin
            if (i == dec_idx)
                dec_code[i] = 1'b1;
        end
    end

    // Output register and buffer occupancy; reset outranks flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            skid_vld_p0 <= 1'b0;
            in_ready    <= 1'b1;
            code        <= '0;
            illegal     <= 1'b0;
            out_word_p1 <= '0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            skid_vld_p0 <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            if (take_skid || take_in) begin
                code        <= dec_code;
                illegal     <= dec_illegal;
                out_word_p1 <= load_word[25:0];
                out_valid   <= 1'b1;
            end else if (load_out) begin
                out_valid   <= 1'b0;
            end
            skid_vld_p0 <= skid_next;
            in_ready    <= !skid_next;
        end
    end

    // Skid data capture; occupancy is tracked separately so no reset is needed.
    always_ff @(posedge clk) begin
        if (!load_out && in_fire)
            skid_word_p0 <= instr_in;
    end

    assign rs       = out_word_p1[25:21];
    assign rt       = out_word_p1[20:16];
    assign rd       = out_word_p1[15:11];
    assign shamt    = out_word_p1[10:6];
    assign imm16    = out_word_p1[15:0];
    assign target26 = out_word_p1[25:0];

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: one EXT_EN=1 and one EXT_EN=0
// instance share the same stimulus.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] instr_in;
    logic        in_ready, out_valid, illegal;
    logic [63:0] code;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic        in_ready0, out_valid0, illegal0;
    logic [63:0] code0;
    logic [4:0]  rs0, rt0, rd0, shamt0;
    logic [15:0] imm160;
    logic [25:0] target260;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_decode_stage #(.EXT_EN(1), .CODE_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .instr_in(instr_in), .out_valid(out_valid),
        .out_ready(out_ready), .code(code), .illegal(illegal), .rs(rs),
        .rt(rt), .rd(rd), .shamt(shamt), .imm16(imm16), .target26(target26)
    );

    instr_decode_stage #(.EXT_EN(0), .CODE_W(64)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready0), .instr_in(instr_in), .out_valid(out_valid0),
        .out_ready(out_ready), .code(code0), .illegal(illegal0), .rs(rs0),
        .rt(rt0), .rd(rd0), .shamt(shamt0), .imm16(imm160), .target26(target260)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        instr_in = 32'h00851020;
        step();
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (code !== 64'd0) begin n_bad++; $display("FAIL reset_code got %h want 0", code); end
        n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal got %b want 0", illegal); end
        n_cmp++; if (target26 !== 26'd0) begin n_bad++; $display("FAIL reset_fields got %h want 0", target26); end
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
        step();
    endtask

    task automatic test_add();
        in_valid = 1'b1; instr_in = 32'h00851020; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid got %b want 1", out_valid); end
        n_cmp++; if (code !== 64'd1) begin n_bad++; $display("FAIL add_code got %h want %h", code, 64'd1); end
        n_cmp++; if ({rs, rt, rd} !== {5'd4, 5'd5, 5'd2}) begin n_bad++; $display("FAIL add_fields got %0d/%0d/%0d want 4/5/2", rs, rt, rd); end
        n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL add_illegal got %b want 0", illegal); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1;
        instr_in = 32'h2004FFFF;
        step();
        instr_in = 32'h8C430008;
        n_cmp++; if (code !== (64'd1 << 17)) begin n_bad++; $display("FAIL b2b_addi got %h want %h", code, 64'd1 << 17); end
        n_cmp++; if (imm16 !== 16'hFFFF) begin n_bad++; $display("FAIL b2b_imm_ffff got %h want ffff", imm16); end
        step();
        instr_in = 32'h0C000010;
        n_cmp++; if (code !== (64'd1 << 22)) begin n_bad++; $display("FAIL b2b_lw got %h want %h", code, 64'd1 << 22); end
        n_cmp++; if (imm16 !== 16'h0008) begin n_bad++; $display("FAIL b2b_imm_0008 got %h want 0008", imm16); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (code !== (64'd1 << 30) || out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_jal got %h/%b want %h/1", code, out_valid, 64'd1 << 30); end
        n_cmp++; if (target26 !== 26'h0000010) begin n_bad++; $display("FAIL b2b_target got %h want 0000010", target26); end
        step();
    endtask

    task automatic test_ext();
        logic [31:0] words [3];
        int          bits [3];
        words[0] = 32'h00850018; bits[0] = 31;
        words[1] = 32'h42000018; bits[1] = 53;
        words[2] = 32'h04810003; bits[2] = 43;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; instr_in = words[i];
            step();
            n_cmp++; if (code !== (64'd1 << bits[i]) || illegal !== 1'b0) begin n_bad++; $display("FAIL ext_on_%0d got %h/%b want %h/0", i, code, illegal, 64'd1 << bits[i]); end
            n_cmp++; if (code0 !== 64'd0 || illegal0 !== 1'b1 || out_valid0 !== 1'b1) begin n_bad++; $display("FAIL ext_off_%0d got %h/%b/%b want 0/1/1", i, code0, illegal0, out_valid0); end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1; in_valid = 1'b1; instr_in = 32'hFC000000;
        step();
        in_valid = 1'b0;
        n_cmp++; if (illegal !== 1'b1 || code !== 64'd0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL illegal got %b/%h/%b want 1/0/1", illegal, code, out_valid); end
        step();
    endtask

    task automatic test_stall();
        out_ready = 1'b0; in_valid = 1'b1; instr_in = 32'h00851020;
        step();
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_first got rdy %b vld %b want 1/1", in_ready, out_valid); end
        instr_in = 32'h2004FFFF;
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready_low got %b want 0", in_ready); end
        instr_in = 32'h8C430008;
        step();
        n_cmp++; if (code !== 64'd1 || rd !== 5'd2 || in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_hold got %h rd %0d rdy %b want 1 rd 2 rdy 0", code, rd, in_ready); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (code !== (64'd1 << 17) || out_valid !== 1'b1 || in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_second got %h/%b/%b want %h/1/1", code, out_valid, in_ready, 64'd1 << 17); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (code !== (64'd1 << 22) || out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_third got %h/%b want %h/1", code, out_valid, 64'd1 << 22); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_no_dup got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; instr_in = 32'h00851020;
        step();
        instr_in = 32'h2004FFFF;
        step();
        flush = 1'b1; instr_in = 32'h8C430008;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_state got vld %b rdy %b want 0/1", out_valid, in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_stale_%0d got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0; in_valid = 1'b1; instr_in = 32'h2004FFFF;
        step();
        instr_in = 32'h8C430008;
        step();
        in_valid = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || code !== 64'd0) begin n_bad++; $display("FAIL rst_mid got %b/%b/%h want 0/1/0", out_valid, in_ready, code); end
        out_ready = 1'b1; in_valid = 1'b1; instr_in = 32'h00851020;
        step();
        in_valid = 1'b0;
        n_cmp++; if (code !== 64'd1 || out_valid !== 1'b1 || rs !== 5'd4) begin n_bad++; $display("FAIL rst_mid_next got %h/%b rs %0d want 1/1 rs 4", code, out_valid, rs); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_drain got %b want 0", out_valid); end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr_in = 32'h0;
        test_reset();
        test_add();
        test_back_to_back();
        test_ext();
        test_illegal();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
